// File: rtl/video_stream_tx_if.sv
// Pixel-RAM read port and video output bus of video_stream_tx.
// The transmitter drives the master side; RAM and video sink sit on the slave side.
interface video_stream_tx_if;
   logic        rd_en;
   logic [19:0] rd_addr;
   logic [7:0]  rd_data;
   logic        img_vsync;
   logic        img_href;
   logic [7:0]  img_gray;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data,
      output img_vsync,
      output img_href,
      output img_gray
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data,
      input  img_vsync,
      input  img_href,
      input  img_gray
   );
endinterface

// File: rtl/video_stream_tx.sv
// Frame-source transmitter: raster-reads an 8-bit image from a 1-cycle-latency pixel RAM and
// emits it as vsync/href/gray with programmable blanking, single-shot or continuous.
module video_stream_tx #(
   parameter logic [10:0] IMG_HDISP = 11'd640,
   parameter logic [10:0] IMG_VDISP = 11'd480,
   parameter logic [10:0] H_BLANK   = 11'd160,
   parameter logic [15:0] VS_LEAD   = 16'd100,
   parameter logic [15:0] VS_TAIL   = 16'd100,
   parameter logic [15:0] FRAME_GAP = 16'd200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              continuous,
   output logic              busy,
   output logic              frame_done,
   video_stream_tx_if.master vid
);

   typedef enum logic [2:0] {StIdle, StLead, StActive, StHblank, StTail, StGap} state_e;

   localparam logic [10:0] HdispLast  = IMG_HDISP - 11'd1;
   localparam logic [10:0] VdispLast  = IMG_VDISP - 11'd1;
   localparam logic [15:0] HblankLast = {5'd0, H_BLANK} - 16'd1;
   localparam logic [15:0] LeadLast   = VS_LEAD - 16'd1;
   localparam logic [15:0] TailLast   = VS_TAIL - 16'd1;
   localparam logic [15:0] GapLast    = FRAME_GAP - 16'd1;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [10:0] h_q, h_d;
   logic [10:0] v_q, v_d;
   logic [19:0] addr_q, addr_d;
   logic        vsync_q, vsync_d;
   logic        href_q, href_d;
   logic [2:0]  vs_pipe_q;
   logic [1:0]  hr_pipe_q;
   logic [7:0]  gray_q;
   logic        frame_done_q;

   // Busy also covers the two output delay stages so the video tail is never cut short.
   assign busy = (state_q != StIdle) | vs_pipe_q[0] | vs_pipe_q[1];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      h_d     = h_q;
      v_d     = v_q;
      addr_d  = addr_q;
      case (state_q)
         StIdle: begin
            if (start && !busy) begin
               state_d = StLead;
               cnt_d   = '0;
               addr_d  = '0;
            end
         end
         StLead: begin
            if (cnt_q == LeadLast) begin
               state_d = StActive;
               cnt_d   = '0;
               h_d     = '0;
               v_d     = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StActive: begin
            if (h_q == HdispLast) begin
               h_d   = '0;
               cnt_d = '0;
               if (v_q == VdispLast) begin
                  // Last pixel of the frame: address stays on it.
                  state_d = StTail;
               end else begin
                  state_d = StHblank;
                  addr_d  = addr_q + 20'd1;
               end
            end else begin
               h_d    = h_q + 11'd1;
               addr_d = addr_q + 20'd1;
            end
         end
         StHblank: begin
            if (cnt_q == HblankLast) begin
               state_d = StActive;
               cnt_d   = '0;
               h_d     = '0;
               v_d     = v_q + 11'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StTail: begin
            if (cnt_q == TailLast) begin
               state_d = StGap;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StGap: begin
            if (cnt_q == GapLast) begin
               cnt_d = '0;
               if (continuous) begin
                  state_d = StLead;
                  addr_d  = '0;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign vsync_d = (state_d != StIdle) && (state_d != StGap);
   assign href_d  = (state_d == StActive);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         h_q          <= '0;
         v_q          <= '0;
         addr_q       <= '0;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         vs_pipe_q    <= '0;
         hr_pipe_q    <= '0;
         gray_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         h_q          <= h_d;
         v_q          <= v_d;
         addr_q       <= addr_d;
         vsync_q      <= vsync_d;
         href_q       <= href_d;
         vs_pipe_q    <= {vs_pipe_q[1:0], vsync_q};
         hr_pipe_q    <= {hr_pipe_q[0], href_q};
         gray_q       <= hr_pipe_q[0] ? vid.rd_data : 8'd0;
         // Pulse lands one cycle after the delayed vsync has fallen.
         frame_done_q <= vs_pipe_q[2] & ~vs_pipe_q[1];
      end
   end

   assign vid.rd_en     = href_q;
   assign vid.rd_addr   = addr_q;
   assign vid.img_vsync = vs_pipe_q[1];
   assign vid.img_href  = hr_pipe_q[1];
   assign vid.img_gray  = gray_q;
   assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_video_stream_tx.sv
// Bench for video_stream_tx: a small and a mid-size instance are checked every cycle against a
// frame-timeline model, plus scenario tables and hand-written corner sequences.
`timescale 1ns/1ps
module tb_video_stream_tx;

   localparam int SH = 4,  SV = 3,  SHB = 2,  SLD = 3,  STL = 3, SGP = 5;
   localparam int MH = 37, MV = 23, MHB = 11, MLD = 17, MTL = 9, MGP = 13;

   typedef struct { int h; int v; int hb; int ld; int tl; int gp; } cfg_t;
   typedef struct packed {
      logic busy; logic fd; logic rd_en; logic [19:0] addr; logic vs; logic hr; logic [7:0] gray;
   } obs_t;
   typedef struct {
      int s0; int s1; int s2; bit cont; int drop; int cyc;
      int vs; int hr; int fd; int rd; bit busy;
   } vec_t;

   logic clk, rst_n;
   logic start_s, cont_s, busy_s, fd_s;
   logic start_m, cont_m, busy_m, fd_m;
   logic [7:0] ram_s [16];
   logic [7:0] ram_m [1024];

   video_stream_tx_if if_s ();
   video_stream_tx_if if_m ();

   video_stream_tx #(
      .IMG_HDISP(11'(SH)), .IMG_VDISP(11'(SV)), .H_BLANK(11'(SHB)),
      .VS_LEAD(16'(SLD)), .VS_TAIL(16'(STL)), .FRAME_GAP(16'(SGP))
   ) u_dut_s (
      .clk(clk), .rst_n(rst_n), .start(start_s), .continuous(cont_s),
      .busy(busy_s), .frame_done(fd_s), .vid(if_s)
   );

   video_stream_tx #(
      .IMG_HDISP(11'(MH)), .IMG_VDISP(11'(MV)), .H_BLANK(11'(MHB)),
      .VS_LEAD(16'(MLD)), .VS_TAIL(16'(MTL)), .FRAME_GAP(16'(MGP))
   ) u_dut_m (
      .clk(clk), .rst_n(rst_n), .start(start_m), .continuous(cont_m),
      .busy(busy_m), .frame_done(fd_m), .vid(if_m)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (if_s.rd_en) if_s.rd_data <= ram_s[if_s.rd_addr[3:0]];
      if (if_m.rd_en) if_m.rd_data <= ram_m[if_m.rd_addr[9:0]];
   end

   int   n_checks = 0, n_fail = 0, cyc = 0;
   bit   m_act [2];
   int   m_pos [2];
   obs_t snap_s, snap_m;
   int   cnt_vs, cnt_hr, cnt_fd, cnt_rd, max_addr_m;
   vec_t tv [4];

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic cfg_t get_cfg(bit d);
      cfg_t c;
      if (d) begin
         c.h = MH; c.v = MV; c.hb = MHB; c.ld = MLD; c.tl = MTL; c.gp = MGP;
      end else begin
         c.h = SH; c.v = SV; c.hb = SHB; c.ld = SLD; c.tl = STL; c.gp = SGP;
      end
      return c;
   endfunction

   function automatic int frame_len(cfg_t c);
      return c.ld + c.v * c.h + (c.v - 1) * c.hb + c.tl;
   endfunction

   // Pixel index read at frame offset k (offset 0 = first lead clock), or -1 if none.
   function automatic int pix_at(cfg_t c, int k);
      int j, per;
      j = k - c.ld;
      if (j < 0 || j >= c.v * c.h + (c.v - 1) * c.hb) return -1;
      per = c.h + c.hb;
      if (j % per >= c.h) return -1;
      return (j / per) * c.h + j % per;
   endfunction

   function automatic logic [7:0] ram_val(bit d, int p);
      return d ? ram_m[p[9:0]] : ram_s[p[3:0]];
   endfunction

   function automatic obs_t expect_at(bit d, int pos);
      obs_t e;
      cfg_t c;
      int   f, p;
      e = '0;
      c = get_cfg(d);
      f = frame_len(c);
      e.busy = 1'b1;
      p = pix_at(c, pos);
      if (p >= 0) begin e.rd_en = 1'b1; e.addr = 20'(p); end
      p = pix_at(c, pos - 2);
      if (p >= 0) begin e.hr = 1'b1; e.gray = ram_val(d, p); end
      e.vs = (pos >= 2) && (pos < f + 2);
      e.fd = (pos == f + 3);
      return e;
   endfunction

   function automatic obs_t get_obs(bit d);
      obs_t o;
      if (d) o = {busy_m, fd_m, if_m.rd_en, if_m.rd_addr, if_m.img_vsync, if_m.img_href,
                  if_m.img_gray};
      else   o = {busy_s, fd_s, if_s.rd_en, if_s.rd_addr, if_s.img_vsync, if_s.img_href,
                  if_s.img_gray};
      return o;
   endfunction

   // Called at posedge+1: compare at negedge, advance the model, return at next posedge+1.
   task automatic cycle();
      obs_t a, e;
      bit   d, st, ct;
      cfg_t c;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         d = i[0];
         a = get_obs(d);
         if (d) snap_m = a; else snap_s = a;
         e = m_act[d] ? expect_at(d, m_pos[d]) : '0;
         if (!e.rd_en) a.addr = '0;
         check($sformatf("trace dut%0d cycle %0d", i, cyc), a, e);
      end
      if (snap_s.vs) cnt_vs++;
      if (snap_s.hr) cnt_hr++;
      if (snap_s.fd) cnt_fd++;
      if (snap_s.rd_en) cnt_rd++;
      if (snap_m.rd_en && int'(snap_m.addr) > max_addr_m) max_addr_m = int'(snap_m.addr);
      for (int i = 0; i < 2; i++) begin
         d  = i[0];
         st = d ? start_m : start_s;
         ct = d ? cont_m : cont_s;
         c  = get_cfg(d);
         if (!rst_n) m_act[d] = 1'b0;
         else if (m_act[d]) begin
            if (m_pos[d] == frame_len(c) + c.gp - 1) begin
               if (ct) m_pos[d] = 0;
               else m_act[d] = 1'b0;
            end else m_pos[d]++;
         end else if (st) begin
            m_act[d] = 1'b1;
            m_pos[d] = 0;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run_step(int idx, vec_t r);
      cnt_vs = 0; cnt_hr = 0; cnt_fd = 0; cnt_rd = 0;
      cont_s = r.cont;
      for (int i = 0; i < r.cyc; i++) begin
         start_s = (i == r.s0) || (i == r.s1) || (i == r.s2);
         if (i == r.drop) cont_s = 1'b0;
         cycle();
      end
      start_s = 1'b0;
      check($sformatf("step%0d vsync_clocks", idx), cnt_vs, r.vs);
      check($sformatf("step%0d href_clocks", idx), cnt_hr, r.hr);
      check($sformatf("step%0d frame_done_pulses", idx), cnt_fd, r.fd);
      check($sformatf("step%0d rd_en_clocks", idx), cnt_rd, r.rd);
      check($sformatf("step%0d busy_at_end", idx), snap_s.busy, r.busy);
   endtask

   task automatic wait_idle(string name);
      for (int i = 0; i < 4000 && (busy_s || busy_m); i++) cycle();
      check(name, {busy_s, busy_m}, 2'b00);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t_busy, t_rd, t_hr, gap, low;
      bit seen_hi, found;
      logic [7:0] g;
      rst_n = 1'b0; start_s = 1'b0; start_m = 1'b0; cont_s = 1'b0; cont_m = 1'b0;
      m_act[0] = 1'b0; m_act[1] = 1'b0; m_pos[0] = 0; m_pos[1] = 0;
      max_addr_m = -1;
      for (int i = 0; i < 16; i++) ram_s[i] = 8'(i + 10);
      for (int i = 0; i < 1024; i++) ram_m[i] = 8'($urandom);
      //         s0  s1  s2 cont drop cyc  vs  hr fd  rd busy
      tv[0] = '{0,  -1, -1, 1'b0, -1, 40, 22, 12, 1, 12, 1'b0};
      tv[1] = '{-1, -1, -1, 1'b0, -1, 20,  0,  0, 0,  0, 1'b0};
      tv[2] = '{0,  10, 25, 1'b0, -1, 40, 22, 12, 1, 12, 1'b0};
      tv[3] = '{0,  -1, -1, 1'b1, 40, 70, 44, 24, 2, 24, 1'b0};

      repeat (3) @(posedge clk);
      #1;
      check("reset outputs small", get_obs(1'b0), '0);
      check("reset outputs mid", get_obs(1'b1), '0);
      rst_n = 1'b1;
      cycle();

      for (int i = 0; i < 4; i++) run_step(i, tv[i]);
      check("rd_addr held at last pixel", if_s.rd_addr, SH * SV - 1);

      // Latency from lead entry to first read and from read to visible pixel.
      t_busy = -1; t_rd = -1; t_hr = -1; g = '0;
      start_s = 1'b1; cycle(); start_s = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cycle();
         if (snap_s.busy && t_busy < 0) t_busy = i;
         if (snap_s.rd_en && t_rd < 0) t_rd = i;
         if (snap_s.hr && t_hr < 0) begin t_hr = i; g = snap_s.gray; end
      end
      check("busy right after start", t_busy, 0);
      check("lead entry to first rd_en", t_rd - t_busy, SLD);
      check("rd_en to img_href", t_hr - t_rd, 2);
      check("first gray", g, 8'd10);
      wait_idle("drain after latency frame");

      // Continuous: vsync-low run between back-to-back frames.
      cont_s = 1'b1; start_s = 1'b1; cycle(); start_s = 1'b0;
      seen_hi = 1'b0; low = 0; gap = -1;
      for (int i = 0; i < 80 && gap < 0; i++) begin
         cycle();
         if (snap_s.vs) begin
            if (seen_hi && low > 0) gap = low;
            seen_hi = 1'b1; low = 0;
         end else if (seen_hi) low++;
      end
      check("continuous vsync gap", gap, SGP);
      cont_s = 1'b0;
      wait_idle("drain after continuous");

      // Asynchronous reset while the second line is being read.
      start_s = 1'b1; cycle(); start_s = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle();
         if (snap_s.rd_en && snap_s.addr == 20'd5) found = 1'b1;
      end
      check("reached second line", found, 1'b1);
      rst_n = 1'b0;
      m_act[0] = 1'b0; m_act[1] = 1'b0;
      #1;
      check("async reset outputs small", get_obs(1'b0), '0);
      check("async reset outputs mid", get_obs(1'b1), '0);
      cycle();
      rst_n = 1'b1;
      run_step(4, tv[0]);

      // Randomized traffic on both instances.
      start_m = 1'b1; cycle(); start_m = 1'b0;
      cont_s = 1'($urandom_range(0, 1));
      cont_m = 1'($urandom_range(0, 1));
      for (int i = 0; i < 6000; i++) begin
         start_s = ($urandom_range(0, 39) == 0);
         start_m = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 299) == 0) cont_s = ~cont_s;
         if ($urandom_range(0, 299) == 0) cont_m = ~cont_m;
         cycle();
      end
      start_s = 1'b0; start_m = 1'b0; cont_s = 1'b0; cont_m = 1'b0;
      wait_idle("drain after random traffic");
      check("mid instance highest address", max_addr_m, MH * MV - 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
